// File: rtl/cpu_master_alu_pkg.sv
// Shared definitions for the cpu_master_alu slice: opcode and condition-code
// encodings, flag bit positions, and a helper that packs {N,Z,C,V}.
// Optional feature macro used by this slice: CPU_MASTER_ALU_MUL_EN (enables MUL).
package cpu_master_alu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned MOVIMM_W = 16;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned COND_W   = 4;
  localparam int unsigned FLAG_W   = 4;

  // Flag bit positions inside the 4-bit flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_ORR = 4'b0011,
    OP_AND = 4'b0100,
    OP_EOR = 4'b0101,
    OP_MOV = 4'b0110,
    OP_LSR = 4'b0111,
    OP_LSL = 4'b1000,
    OP_ROR = 4'b1001,
    OP_NOP = 4'b1010,
    OP_CMP = 4'b1011,
    OP_LDR = 4'b1100,
    OP_STR = 4'b1101,
    OP_MVN = 4'b1110,
    OP_BIC = 4'b1111
  } opcode_e;

  typedef enum logic [COND_W-1:0] {
    CC_EQ = 4'b0000,
    CC_NE = 4'b0001,
    CC_CS = 4'b0010,
    CC_CC = 4'b0011,
    CC_MI = 4'b0100,
    CC_PL = 4'b0101,
    CC_VS = 4'b0110,
    CC_VC = 4'b0111,
    CC_HI = 4'b1000,
    CC_LS = 4'b1001,
    CC_GE = 4'b1010,
    CC_LT = 4'b1011,
    CC_GT = 4'b1100,
    CC_LE = 4'b1101,
    CC_AL = 4'b1110,
    CC_NV = 4'b1111
  } cond_e;

  // Place individual flags at their defined bit positions
  function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic z,
                                                   input logic c, input logic v);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/cpu_master_alu_cond.sv
// ARM-style condition evaluation.
// Ports: Cond (condition code), Flag ({N,Z,C,V}), pass (combinational: condition holds).
module cpu_master_alu_cond
  import cpu_master_alu_pkg::*;
(
  input  logic [COND_W-1:0] Cond,
  input  logic [FLAG_W-1:0] Flag,
  output logic              pass
);

  logic n, z, c, v;

  assign n = Flag[FLAG_N];
  assign z = Flag[FLAG_Z];
  assign c = Flag[FLAG_C];
  assign v = Flag[FLAG_V];

  // Decode condition against current flags
  always_comb begin
    pass = 1'b0;
    case (cond_e'(Cond))
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_master_alu.sv
// Conditionally executed ALU with one-cycle registered latency.
// Ports: Clk, Reset (async active-low), Reg1/Reg2 (operands A/B),
//   IV_ShftRor (shift amount / LDR-STR offset), IV_Mov (MOV immediate),
//   OpCode, Cond, S (set flags), Flag (current {N,Z,C,V}),
//   Result, New_Flag, memory_enable (all registered).
// Macro CPU_MASTER_ALU_MUL_EN: includes the multiplier; otherwise opcode MUL acts as NOP.
module cpu_master_alu
  import cpu_master_alu_pkg::*;
(
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic signed [DATA_W-1:0]   Reg1,
  input  logic signed [DATA_W-1:0]   Reg2,
  input  logic        [SHAMT_W-1:0]  IV_ShftRor,
  input  logic        [MOVIMM_W-1:0] IV_Mov,
  input  logic        [OP_W-1:0]     OpCode,
  input  logic        [COND_W-1:0]   Cond,
  input  logic                       S,
  input  logic        [FLAG_W-1:0]   Flag,
  output logic signed [DATA_W-1:0]   Result,
  output logic        [FLAG_W-1:0]   New_Flag,
  output logic                       memory_enable
);

  logic              cond_pass;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              add_v;
  logic              sub_v;
  logic [DATA_W-1:0] eff_addr;
  logic [DATA_W:0]   lsl_w;
  logic [DATA_W:0]   lsr_w;
  logic [DATA_W-1:0] ror_res;
  logic              shamt_nz;

  logic [DATA_W-1:0] res_d;
  logic [FLAG_W-1:0] flag_d;
  logic              mem_d;
  logic [DATA_W-1:0] flag_src;
  logic              set_flags;
  logic              c_new;
  logic              v_new;

  cpu_master_alu_cond u_cond (
    .Cond (Cond),
    .Flag (Flag),
    .pass (cond_pass)
  );

  // Arithmetic with an extra bit to capture carry / borrow
  assign sum   = {1'b0, Reg1} + {1'b0, Reg2};
  assign diff  = {1'b0, Reg1} - {1'b0, Reg2};
  assign add_v = (Reg1[DATA_W-1] == Reg2[DATA_W-1]) && (sum[DATA_W-1] != Reg1[DATA_W-1]);
  assign sub_v = (Reg1[DATA_W-1] != Reg2[DATA_W-1]) && (diff[DATA_W-1] != Reg1[DATA_W-1]);

  assign eff_addr = Reg1 + DATA_W'(IV_ShftRor);

  // Extra bit catches the last bit shifted out (top bit for LSL, bit 0 for LSR)
  assign lsl_w    = {1'b0, Reg1} << IV_ShftRor;
  assign lsr_w    = {Reg1, 1'b0} >> IV_ShftRor;
  assign ror_res  = DATA_W'({Reg1, Reg1} >> IV_ShftRor);
  assign shamt_nz = (IV_ShftRor != '0);

`ifdef CPU_MASTER_ALU_MUL_EN
  logic [DATA_W-1:0] mul_lo;
  assign mul_lo = DATA_W'(Reg1 * Reg2);
`endif

  // Next-state result, flags and memory strobe
  always_comb begin
    res_d     = '0;
    flag_d    = Flag;
    mem_d     = 1'b0;
    flag_src  = '0;
    set_flags = 1'b0;
    c_new     = Flag[FLAG_C];
    v_new     = Flag[FLAG_V];

    if (cond_pass) begin
      case (opcode_e'(OpCode))
        OP_ADD: begin
          res_d     = sum[DATA_W-1:0];
          flag_src  = res_d;
          set_flags = S;
          c_new     = sum[DATA_W];
          v_new     = add_v;
        end
        OP_SUB: begin
          res_d     = diff[DATA_W-1:0];
          flag_src  = res_d;
          set_flags = S;
          c_new     = !diff[DATA_W];
          v_new     = sub_v;
        end
`ifdef CPU_MASTER_ALU_MUL_EN
        OP_MUL: begin
          res_d     = mul_lo;
          flag_src  = res_d;
          set_flags = S;
        end
        OP_NOP: ;
`else
        OP_MUL, OP_NOP: ;
`endif
        OP_ORR: begin
          res_d     = Reg1 | Reg2;
          flag_src  = res_d;
          set_flags = S;
        end
        OP_AND: begin
          res_d     = Reg1 & Reg2;
          flag_src  = res_d;
          set_flags = S;
        end
        OP_EOR: begin
          res_d     = Reg1 ^ Reg2;
          flag_src  = res_d;
          set_flags = S;
        end
        OP_MOV: begin
          res_d     = DATA_W'(IV_Mov);
          flag_src  = res_d;
          set_flags = S;
        end
        OP_LSR: begin
          res_d     = lsr_w[DATA_W:1];
          flag_src  = res_d;
          set_flags = S;
          if (shamt_nz) c_new = lsr_w[0];
        end
        OP_LSL: begin
          res_d     = lsl_w[DATA_W-1:0];
          flag_src  = res_d;
          set_flags = S;
          if (shamt_nz) c_new = lsl_w[DATA_W];
        end
        OP_ROR: begin
          res_d     = ror_res;
          flag_src  = res_d;
          set_flags = S;
          if (shamt_nz) c_new = ror_res[DATA_W-1];
        end
        OP_CMP: begin
          // Flags always come from A-B; the difference itself is not written
          flag_src  = diff[DATA_W-1:0];
          set_flags = 1'b1;
          c_new     = !diff[DATA_W];
          v_new     = sub_v;
        end
        OP_LDR, OP_STR: begin
          res_d = eff_addr;
          mem_d = 1'b1;
        end
        OP_MVN: begin
          res_d     = ~Reg2;
          flag_src  = res_d;
          set_flags = S;
        end
        OP_BIC: begin
          res_d     = Reg1 & ~Reg2;
          flag_src  = res_d;
          set_flags = S;
        end
      endcase

      if (set_flags) begin
        flag_d = pack_flags(flag_src[DATA_W-1], (flag_src == '0), c_new, v_new);
      end
    end
  end

  // Output registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Result        <= '0;
      New_Flag      <= '0;
      memory_enable <= 1'b0;
    end else begin
      Result        <= res_d;
      New_Flag      <= flag_d;
      memory_enable <= mem_d;
    end
  end

endmodule

// File: tb/tb_cpu_master_alu.sv
// Directed self-checking bench for cpu_master_alu.
module tb_cpu_master_alu;

  logic               Clk;
  logic               Reset;
  logic signed [31:0] Reg1;
  logic signed [31:0] Reg2;
  logic [4:0]         IV_ShftRor;
  logic [15:0]        IV_Mov;
  logic [3:0]         OpCode;
  logic [3:0]         Cond;
  logic               S;
  logic [3:0]         Flag;
  logic signed [31:0] Result;
  logic [3:0]         New_Flag;
  logic               memory_enable;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_master_alu dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Reg1          (Reg1),
    .Reg2          (Reg2),
    .IV_ShftRor    (IV_ShftRor),
    .IV_Mov        (IV_Mov),
    .OpCode        (OpCode),
    .Cond          (Cond),
    .S             (S),
    .Flag          (Flag),
    .Result        (Result),
    .New_Flag      (New_Flag),
    .memory_enable (memory_enable)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Check all three outputs at once
  task automatic chk_all(input string tag, input logic [31:0] r, input logic [3:0] f,
                         input logic m);
    chk({tag, ".result"}, Result, r);
    chk({tag, ".flags"}, 32'(New_Flag), 32'(f));
    chk({tag, ".mem"}, 32'(memory_enable), 32'(m));
  endtask

  // Apply one operation and wait until its registered outputs are visible
  task automatic run(input logic [3:0] op, input logic [3:0] cc, input logic s,
                     input logic [3:0] fl, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [15:0] mv);
    OpCode     = op;
    Cond       = cc;
    S          = s;
    Flag       = fl;
    Reg1       = a;
    Reg2       = b;
    IV_ShftRor = sh;
    IV_Mov     = mv;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0;
    OpCode = 4'b0000; Cond = 4'b1110; S = 1'b1; Flag = 4'b1111;
    Reg1 = 32'd9; Reg2 = 32'd9; IV_ShftRor = 5'd0; IV_Mov = 16'd0;

    #2;
    chk_all("reset_pre_edge", 32'h0, 4'b0000, 1'b0);
    @(posedge Clk);
    #1;
    chk_all("reset_held_edge", 32'h0, 4'b0000, 1'b0);
    Reset = 1'b1;

    // ADD overflow: N and V set
    run(4'b0000, 4'b1110, 1'b1, 4'b0000, 32'h7FFFFFFF, 32'h1, 5'd0, 16'h0);
    chk_all("add_ovf", 32'h80000000, 4'b1001, 1'b0);

    // SUB equal operands: Z and C (no borrow)
    run(4'b0001, 4'b1110, 1'b1, 4'b0000, 32'd5, 32'd5, 5'd0, 16'h0);
    chk_all("sub_eq", 32'h0, 4'b0110, 1'b0);

    // MOV EQ with Z clear: not executed, flags pass through
    run(4'b0110, 4'b0000, 1'b0, 4'b1001, 32'h0, 32'h0, 5'd0, 16'hAAA5);
    chk_all("mov_eq_fail", 32'h0, 4'b1001, 1'b0);

    // MOV EQ with Z set: executes, S=0 keeps flags
    run(4'b0110, 4'b0000, 1'b0, 4'b0100, 32'h0, 32'h0, 5'd0, 16'hAAA5);
    chk_all("mov_eq_pass", 32'h0000AAA5, 4'b0100, 1'b0);

    // ROR by 1: bit 0 wraps to bit 31, C = result[31]
    run(4'b1001, 4'b1110, 1'b1, 4'b0000, 32'h00000001, 32'h0, 5'd1, 16'h0);
    chk_all("ror1", 32'h80000000, 4'b1010, 1'b0);

    // STR effective address, then NOP drops memory_enable
    run(4'b1101, 4'b1110, 1'b1, 4'b0011, 32'd4, 32'h0, 5'd3, 16'h0);
    chk_all("str", 32'd7, 4'b0011, 1'b1);
    run(4'b1010, 4'b1110, 1'b1, 4'b0011, 32'd4, 32'h0, 5'd3, 16'h0);
    chk_all("nop", 32'h0, 4'b0011, 1'b0);

    // ADD with S=0 leaves flags alone
    run(4'b0000, 4'b1110, 1'b0, 4'b0101, 32'd3, 32'd4, 5'd0, 16'h0);
    chk_all("add_nos", 32'd7, 4'b0101, 1'b0);

    // ADD wrap to zero: Z and C
    run(4'b0000, 4'b1110, 1'b1, 4'b0000, 32'hFFFFFFFF, 32'h1, 5'd0, 16'h0);
    chk_all("add_wrap", 32'h0, 4'b0110, 1'b0);

    // CMP 3-5 with S=0: flags still updated (N, borrow so C=0), result 0
    run(4'b1011, 4'b1110, 1'b0, 4'b0000, 32'd3, 32'd5, 5'd0, 16'h0);
    chk_all("cmp_lt", 32'h0, 4'b1000, 1'b0);

    // LSR by 1: carry = old bit 0, V kept from Flag
    run(4'b0111, 4'b1110, 1'b1, 4'b0001, 32'h00000003, 32'h0, 5'd1, 16'h0);
    chk_all("lsr1", 32'h1, 4'b0011, 1'b0);

    // LSL by 1: carry = old bit 31
    run(4'b1000, 4'b1110, 1'b1, 4'b0000, 32'h80000001, 32'h0, 5'd1, 16'h0);
    chk_all("lsl1", 32'h2, 4'b0010, 1'b0);

    // LSR by 0: pass-through, C unchanged
    run(4'b0111, 4'b1110, 1'b1, 4'b0010, 32'h80000000, 32'h0, 5'd0, 16'h0);
    chk_all("lsr0", 32'h80000000, 4'b1010, 1'b0);

    // Condition "never"
    run(4'b0000, 4'b1111, 1'b1, 4'b0110, 32'd1, 32'd1, 5'd0, 16'h0);
    chk_all("cond_nv", 32'h0, 4'b0110, 1'b0);

    // LDR under NE with Z set: suppressed, no memory strobe
    run(4'b1100, 4'b0001, 1'b0, 4'b0100, 32'd100, 32'h0, 5'd2, 16'h0);
    chk_all("ldr_ne_fail", 32'h0, 4'b0100, 1'b0);

    // LDR under NE with Z clear
    run(4'b1100, 4'b0001, 1'b0, 4'b0000, 32'd100, 32'h0, 5'd31, 16'h0);
    chk_all("ldr_ne_pass", 32'd131, 4'b0000, 1'b1);

    // EOR to zero: Z set, C/V carried from Flag
    run(4'b0101, 4'b1110, 1'b1, 4'b1011, 32'hF0F0F0F0, 32'hF0F0F0F0, 5'd0, 16'h0);
    chk_all("eor_zero", 32'h0, 4'b0111, 1'b0);

    // MVN and BIC
    run(4'b1110, 4'b1110, 1'b0, 4'b0000, 32'h0, 32'h0, 5'd0, 16'h0);
    chk_all("mvn", 32'hFFFFFFFF, 4'b0000, 1'b0);
    run(4'b1111, 4'b1110, 1'b0, 4'b0000, 32'h000000FF, 32'h0000000F, 5'd0, 16'h0);
    chk_all("bic", 32'h000000F0, 4'b0000, 1'b0);

    // ORR under GT (N==V, Z=0)
    run(4'b0011, 4'b1100, 1'b0, 4'b1001, 32'h1, 32'h2, 5'd0, 16'h0);
    chk_all("orr_gt", 32'h3, 4'b1001, 1'b0);

    // AND under LE with same flags: LE fails
    run(4'b0100, 4'b1101, 1'b1, 4'b1001, 32'hF, 32'h3, 5'd0, 16'h0);
    chk_all("and_le_fail", 32'h0, 4'b1001, 1'b0);

    // MUL opcode: 3 * -2 when built in, otherwise behaves as NOP
    run(4'b0010, 4'b1110, 1'b1, 4'b0011, 32'd3, 32'hFFFFFFFE, 5'd0, 16'h0);
`ifdef CPU_MASTER_ALU_MUL_EN
    chk_all("mul", 32'hFFFFFFFA, 4'b1011, 1'b0);
`else
    chk_all("mul_as_nop", 32'h0, 4'b0011, 1'b0);
`endif

    // Asynchronous reset between edges during an ADD
    run(4'b0000, 4'b1110, 1'b1, 4'b0000, 32'd3, 32'd4, 5'd0, 16'h0);
    chk_all("add_before_rst", 32'd7, 4'b0000, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 4'b0000, 1'b0);
    Reg1 = 32'd10;
    Reg2 = 32'd20;
    #1;
    Reset = 1'b1;
    #1;
    chk_all("rst_released_no_edge", 32'h0, 4'b0000, 1'b0);
    @(posedge Clk);
    #1;
    chk_all("after_rst", 32'd30, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_master_alu.md
CPU_MASTER_ALU -- requirements
Module: cpu_master_alu

Interface
REQ-001 SHALL have ports: Clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: Reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: Reg1  input  32  signed operand A (source_1 register value).
REQ-004 SHALL have ports: Reg2  input  32  signed operand B (source_2 register value).
REQ-005 SHALL have ports: IV_ShftRor  input  5  immediate shift/rotate amount and LDR/STR offset.
REQ-006 SHALL have ports: IV_Mov  input  16  immediate for MOV.
REQ-007 SHALL have ports: OpCode  input  4  operation select.
REQ-008 SHALL have ports: Cond  input  4  ARM-style condition code.
REQ-009 SHALL have ports: S  input  1  set-flags request.
REQ-010 SHALL have ports: Flag  input  4  current flags {N,Z,C,V} at bits [3:0].
REQ-011 SHALL have ports: Result  output  32  signed registered result.
REQ-012 SHALL have ports: New_Flag  output  4  registered updated flags {N,Z,C,V}.
REQ-013 SHALL have ports: memory_enable  output  1  registered; high for an executed LDR/STR.

Function
REQ-014 SHALL register all outputs on rising Clk, giving one-cycle latency from inputs to Result/New_Flag/memory_enable.
REQ-015 SHALL evaluate Cond against Flag: 0000 EQ Z, 0001 NE !Z, 0010 CS C, 0011 CC !C, 0100 MI N, 0101 PL !N, 0110 VS V, 0111 VC !V, 1000 HI C&!Z, 1001 LS !C|Z, 1010 GE N==V, 1011 LT N!=V, 1100 GT !Z&(N==V), 1101 LE Z|(N!=V), 1110 AL, 1111 never.
REQ-016 SHALL, on failed condition, load Result=0, New_Flag=Flag, memory_enable=0.
REQ-017 SHALL decode OpCode: 0000 ADD A+B; 0001 SUB A-B; 0010 MUL low 32 bits of A*B; 0011 ORR; 0100 AND; 0101 EOR; 0110 MOV zero-extended IV_Mov; 0111 LSR A>>IV_ShftRor (logical); 1000 LSL A<<IV_ShftRor; 1001 ROR A by IV_ShftRor; 1010 NOP; 1011 CMP; 1100 LDR; 1101 STR; 1110 MVN ~B; 1111 BIC A&~B.
REQ-018 SHALL wrap ADD/SUB/MUL modulo 2^32; C = unsigned carry-out (ADD) or NOT borrow (SUB, CMP); V = signed overflow.
REQ-019 SHALL update New_Flag only when S=1 for arithmetic/logic/shift ops; otherwise New_Flag=Flag.
REQ-020 SHALL, for logic/shift/MOV/MVN with S=1: N=Result[31], Z=(Result==0), C = last bit shifted out (shifts, amount>0) else Flag C, V = Flag V.
REQ-021 SHALL treat shift amount 0 as pass-through of A with C unchanged; ROR carry = Result[31] when amount>0.
REQ-022 SHALL, for CMP, set New_Flag from A-B regardless of S and output Result=0.
REQ-023 SHALL, for LDR/STR, output Result = A + zero-extended IV_ShftRor (effective address), flags unchanged, memory_enable=1.
REQ-024 SHALL, for NOP, output Result=0, New_Flag=Flag, memory_enable=0.
REQ-025 SHALL deassert memory_enable for every non-LDR/STR opcode.

Reset
REQ-026 SHALL, while Reset=0, asynchronously force Result=0, New_Flag=4'b0000, memory_enable=0.
REQ-027 SHALL resume evaluation on the first rising Clk after Reset deasserts; a reset mid-operation discards the pending result.

Configuration
REQ-028 SHALL compile MUL in only when macro CPU_MASTER_ALU_MUL_EN is defined.
REQ-029 SHALL, without CPU_MASTER_ALU_MUL_EN, treat opcode 0010 exactly as NOP and instantiate no multiplier.

Structure
REQ-030 SHALL place opcode constants, condition-code constants and flag bit indices (N=3, Z=2, C=1, V=0) in shared package cpu_master_alu_pkg.
REQ-031 SHALL implement condition evaluation as sub-module cpu_master_alu_cond (inputs Cond, Flag; output pass).

Verification
REQ-032 SHALL cover: ADD AL S=1, A=32'h7FFFFFFF, B=1 -> Result=32'h80000000, New_Flag=1001 (N,V) next cycle.
REQ-033 SHALL cover: SUB AL S=1, A=5, B=5 -> Result=0, New_Flag=0110 (Z,C).
REQ-034 SHALL cover: MOV EQ with Flag Z=0, IV_Mov=16'hAAA5 -> Result=0, New_Flag=Flag; then Flag Z=1 -> Result=32'h0000AAA5.
REQ-035 SHALL cover: ROR AL S=1, A=32'h00000001, IV_ShftRor=1 -> Result=32'h80000000, N=1, C=1.
REQ-036 SHALL cover: STR AL, A=4, IV_ShftRor=3 -> Result=7, memory_enable=1; following NOP -> memory_enable=0.
REQ-037 SHALL cover: Reset=0 asserted between edges during ADD -> outputs zero immediately, independent of Clk.
